// File: rtl/sipo_deserializer_if.sv
// Serial receive link bundle: serial/control inputs and the parallel word handshake.
interface sipo_deserializer_if #(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH)
);
    logic             shift_en;
    logic             data_in;
    logic             frame_clr;
    logic             out_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             overrun;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output shift_en, data_in, frame_clr, out_ready, clr_ovr,
        input  data_out, out_valid, overrun, bit_cnt
    );

    modport slave (
        input  shift_en, data_in, frame_clr, out_ready, clr_ovr,
        output data_out, out_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: MSB-first word assembly into a holding register
// with valid/ready handoff and a sticky overrun flag.
module sipo_deserializer #(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input logic                clk,
    input logic                reset,
    sipo_deserializer_if.slave s_bus
);
    typedef enum logic {StEmpty, StFull} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_overrun;

    logic             w_sample;
    logic             w_last;
    logic [WIDTH-1:0] w_word;

    // frame_clr takes priority, so a bit on an abort cycle never counts.
    assign w_sample = s_bus.shift_en & ~s_bus.frame_clr;
    assign w_last   = w_sample && (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_word   = {r_sreg[WIDTH-2:0], s_bus.data_in};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= StEmpty;
            r_sreg      <= '0;
            r_bit_cnt   <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (s_bus.frame_clr) begin
                r_sreg    <= '0;
                r_bit_cnt <= '0;
            end else if (s_bus.shift_en) begin
                r_sreg    <= w_word;
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
            end

            if (s_bus.clr_ovr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                StEmpty: begin
                    if (w_last) begin
                        r_data_out  <= w_word;
                        r_out_valid <= 1'b1;
                        r_state     <= StFull;
                    end
                end
                StFull: begin
                    if (s_bus.out_ready) begin
                        if (w_last) begin
                            r_data_out <= w_word;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= StEmpty;
                        end
                    end else if (w_last) begin
                        // Word is dropped; this assignment overrides a same-cycle clr_ovr.
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= StEmpty;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_bus.data_out  = r_data_out;
    assign s_bus.out_valid = r_out_valid;
    assign s_bus.overrun   = r_overrun;
    assign s_bus.bit_cnt   = r_bit_cnt;
endmodule
